// File: rtl/i2s_pkg.sv
// Shared widths, channel indices and the slot-to-bit mapping for the I2S transmitter.
package i2s_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 64;
  localparam int LEFT       = 0;
  localparam int RIGHT      = 1;

  localparam int BC_W  = $clog2(FRAME_BITS);
  localparam int POS_W = $clog2(SLOT_W);

  typedef logic [1:0][SAMPLE_W-1:0] pair_t;

  // Bit carried by slot bc: MSB sits one BCK after the LRCK edge, tail of each slot is zero.
  function automatic logic slot_bit(input pair_t p, input logic [BC_W-1:0] bc);
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] idx;
    logic             ch;
    pos = bc[POS_W-1:0];
    ch  = bc[BC_W-1] ? 1'(RIGHT) : 1'(LEFT);
    idx = '0;
    slot_bit = 1'b0;
    if (pos >= POS_W'(1) && pos <= POS_W'(SAMPLE_W)) begin
      idx = POS_W'(SAMPLE_W) - pos;
      slot_bit = p[ch][idx];
    end
  endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: 50% duty BCK from MCLK plus single-cycle fall/rise strobes.
module i2s_bck_gen #(
  parameter int BCK_DIV = 4
) (
  input  logic clk,
  input  logic srst,
  output logic bck,
  output logic fall_strobe,
  output logic rise_strobe
);

  localparam int CNT_W = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BCK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(BCK_DIV - 1);

  logic [CNT_W-1:0] count_reg;
  logic             bck_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
      bck_reg   <= 1'b0;
    end else begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
      if (count_reg == HALF_LAST || count_reg == LAST) begin
        bck_reg <= ~bck_reg;
      end
    end
  end

  // Strobes mark the cycle whose closing edge moves BCK; BCK is high at LAST by construction.
  assign fall_strobe = (count_reg == LAST);
  assign rise_strobe = (count_reg == HALF_LAST);
  assign bck         = bck_reg;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S master transmitter: 64 BCK frames, 24-bit MSB-first, one-BCK data delay.
// Build option I2S_TX_UNDERRUN_MUTE_EN: send a silent frame on underrun instead of repeating.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BCK_DIV = 4
) (
  input  logic                MCLK,
  input  logic                RST,
  input  logic [SAMPLE_W-1:0] SAMPLE_L,
  input  logic [SAMPLE_W-1:0] SAMPLE_R,
  input  logic                SAMPLE_VALID,
  output logic                SAMPLE_READY,
  output logic                BCK,
  output logic                LRCK,
  output logic                DATAOUT,
  output logic                UNDERRUN,
  output logic                LED1
);

  localparam logic [BC_W-1:0] LAST_BC = BC_W'(FRAME_BITS - 1);

  logic            bck_fall;
  logic            bck_rise_unused;
  logic [BC_W-1:0] bc_reg;
  logic [BC_W-1:0] bc_next;
  pair_t           sample_in;
  pair_t           hold_reg;
  pair_t           frame_reg;
  pair_t           frame_next;
  logic            hold_full_reg;
  logic            hold_full_next;
  logic            ready_reg;
  logic            lrck_reg;
  logic            dout_reg;
  logic            underrun_reg;
  logic            led_reg;
  logic            accept;
  logic            load;

  // Receivers sampling mid-bit would use the rise strobe; the transmitter only needs falls.
  i2s_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck_gen (
    .clk         (MCLK),
    .srst        (RST),
    .bck         (BCK),
    .fall_strobe (bck_fall),
    .rise_strobe (bck_rise_unused)
  );

  always_comb begin
    sample_in        = '0;
    sample_in[LEFT]  = SAMPLE_L;
    sample_in[RIGHT] = SAMPLE_R;
  end

  assign accept  = SAMPLE_VALID && ready_reg;
  assign load    = bck_fall && (bc_reg == LAST_BC);
  assign bc_next = bc_reg + 1'b1;

  // An accept in the load cycle lands in hold after the frame has already underrun.
  always_comb begin
    hold_full_next = hold_full_reg;
    if (load) begin
      hold_full_next = 1'b0;
    end
    if (accept) begin
      hold_full_next = 1'b1;
    end
  end

  always_comb begin
    frame_next = frame_reg;
    if (load) begin
      if (hold_full_reg) begin
        frame_next = hold_reg;
      end
`ifdef I2S_TX_UNDERRUN_MUTE_EN
      else begin
        frame_next = '0;
      end
`endif
    end
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      bc_reg        <= LAST_BC;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      frame_reg     <= '0;
      ready_reg     <= 1'b0;
      lrck_reg      <= 1'b1;
      dout_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
      led_reg       <= 1'b1;
    end else begin
      hold_full_reg <= hold_full_next;
      ready_reg     <= !hold_full_next;
      frame_reg     <= frame_next;
      underrun_reg  <= load && !hold_full_reg;
      if (accept) begin
        hold_reg <= sample_in;
      end
      if (load) begin
        led_reg <= !hold_full_reg;
      end
      // LRCK and data move together with the BCK falling edge.
      if (bck_fall) begin
        bc_reg   <= bc_next;
        lrck_reg <= bc_next[BC_W-1];
        dout_reg <= slot_bit(frame_next, bc_next);
      end
    end
  end

  assign SAMPLE_READY = ready_reg;
  assign LRCK         = lrck_reg;
  assign DATAOUT      = dout_reg;
  assign UNDERRUN     = underrun_reg;
  assign LED1         = led_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: BCK_DIV 4 and BCK_DIV 2 instances, serial frames decoded by an I2S receiver model.
module tb_i2s_tx;

  typedef struct {
    logic [63:0] d;
    logic [63:0] lr;
    int          cyc;
  } frame_t;

  localparam logic [63:0] LR_EXP = 64'hFFFFFFFF_00000000;
  localparam logic [63:0] F0_EXP = 64'h00FFFFFC_01000002;

  logic        MCLK;
  logic        RST;
  logic [23:0] sample_l;
  logic [23:0] sample_r;
  logic        sample_valid;
  logic        rdy4, bck4, lrck4, dout4, und4, led4;
  logic        rdy2, bck2, lrck2, dout2, und2, led2;

  int vectors;
  int miscompares;
  int cyc;

  frame_t fq4[$];
  frame_t fq2[$];
  int     urq4[$];
  int     urq2[$];
  int     acq4[$];

  i2s_tx #(.BCK_DIV(4)) dut4 (
    .MCLK(MCLK), .RST(RST), .SAMPLE_L(sample_l), .SAMPLE_R(sample_r),
    .SAMPLE_VALID(sample_valid), .SAMPLE_READY(rdy4), .BCK(bck4), .LRCK(lrck4),
    .DATAOUT(dout4), .UNDERRUN(und4), .LED1(led4)
  );

  i2s_tx #(.BCK_DIV(2)) dut2 (
    .MCLK(MCLK), .RST(RST), .SAMPLE_L(sample_l), .SAMPLE_R(sample_r),
    .SAMPLE_VALID(sample_valid), .SAMPLE_READY(rdy2), .BCK(bck2), .LRCK(lrck2),
    .DATAOUT(dout2), .UNDERRUN(und2), .LED1(led2)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge MCLK);
      cyc = cyc + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Receiver for the BCK_DIV 4 instance: samples on BCK rise, frame starts at LRCK falling.
  initial begin
    int          pos;
    logic        bq, lq;
    logic [63:0] d, lv;
    pos = -1000; bq = 1'b0; lq = 1'b1; d = '0; lv = '0;
    forever begin
      @(negedge MCLK);
      if (RST) begin
        pos = -1000; bq = 1'b0; lq = 1'b1;
      end else begin
        if (sample_valid && rdy4) acq4.push_back(cyc);
        if (und4) urq4.push_back(cyc);
        if (bck4 && !bq) begin
          if (!lrck4 && lq) pos = 0;
          else pos = pos + 1;
          if (pos >= 0 && pos < 64) begin
            d[pos]  = dout4;
            lv[pos] = lrck4;
          end
          if (pos == 63) fq4.push_back('{d, lv, cyc});
          lq = lrck4;
        end
        bq = bck4;
      end
    end
  end

  // Same receiver for the BCK_DIV 2 instance.
  initial begin
    int          pos;
    logic        bq, lq;
    logic [63:0] d, lv;
    pos = -1000; bq = 1'b0; lq = 1'b1; d = '0; lv = '0;
    forever begin
      @(negedge MCLK);
      if (RST) begin
        pos = -1000; bq = 1'b0; lq = 1'b1;
      end else begin
        if (und2) urq2.push_back(cyc);
        if (bck2 && !bq) begin
          if (!lrck2 && lq) pos = 0;
          else pos = pos + 1;
          if (pos >= 0 && pos < 64) begin
            d[pos]  = dout2;
            lv[pos] = lrck2;
          end
          if (pos == 63) fq2.push_back('{d, lv, cyc});
          lq = lrck2;
        end
        bq = bck2;
      end
    end
  end

  function automatic logic [63:0] build_frame(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 24; i++) begin
      f[1 + i]  = l[23 - i];
      f[33 + i] = r[23 - i];
    end
    return f;
  endfunction

  // Leaves the bench 1 ns after the last reset edge.
  task automatic do_reset();
    @(posedge MCLK);
    #1 RST = 1'b1;
    sample_valid = 1'b0;
    repeat (3) @(posedge MCLK);
    fq4.delete(); fq2.delete(); urq4.delete(); urq2.delete(); acq4.delete();
    #1 RST = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [23:0] l, input logic [23:0] r, output bit ok);
    ok = 1'b0;
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge MCLK);
      if ((sel ? rdy2 : rdy4) == 1'b1) begin
        @(posedge MCLK);
        #1 ok = 1'b1;
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge MCLK);
    #1 RST = 1'b1;
    @(posedge MCLK);
    @(negedge MCLK);
    vectors++; if (bck4 !== 1'b0) begin miscompares++; $display("FAIL rst_bck got %b want 0", bck4); end
    vectors++; if (lrck4 !== 1'b1) begin miscompares++; $display("FAIL rst_lrck got %b want 1", lrck4); end
    vectors++; if (dout4 !== 1'b0) begin miscompares++; $display("FAIL rst_dout got %b want 0", dout4); end
    vectors++; if (rdy4 !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b want 0", rdy4); end
    vectors++; if (und4 !== 1'b0) begin miscompares++; $display("FAIL rst_underrun got %b want 0", und4); end
    vectors++; if (led4 !== 1'b1) begin miscompares++; $display("FAIL rst_led1 got %b want 1", led4); end
    @(posedge MCLK);
    fq4.delete(); fq2.delete(); urq4.delete(); urq2.delete(); acq4.delete();
    #1 RST = 1'b0;
    @(negedge MCLK);
    vectors++; if (rdy4 !== 1'b0) begin miscompares++; $display("FAIL ready_r0 got %b want 0", rdy4); end
    @(posedge MCLK); @(negedge MCLK);
    vectors++; if (rdy4 !== 1'b1) begin miscompares++; $display("FAIL ready_r1 got %b want 1", rdy4); end
    vectors++; if (lrck2 !== 1'b1) begin miscompares++; $display("FAIL div2_lrck_r1 got %b want 1", lrck2); end
    @(posedge MCLK); @(negedge MCLK);
    vectors++; if (bck4 !== 1'b1) begin miscompares++; $display("FAIL bck_r2 got %b want 1", bck4); end
    vectors++; if (lrck2 !== 1'b0) begin miscompares++; $display("FAIL div2_lrck_r2 got %b want 0", lrck2); end
    @(posedge MCLK); @(negedge MCLK);
    vectors++; if (lrck4 !== 1'b1) begin miscompares++; $display("FAIL lrck_r3 got %b want 1", lrck4); end
    @(posedge MCLK); @(negedge MCLK);
    vectors++; if (lrck4 !== 1'b0) begin miscompares++; $display("FAIL lrck_r4 got %b want 0", lrck4); end
    vectors++; if (bck4 !== 1'b0) begin miscompares++; $display("FAIL bck_r4 got %b want 0", bck4); end
    vectors++; if (und4 !== 1'b1) begin miscompares++; $display("FAIL underrun_r4 got %b want 1", und4); end
    @(posedge MCLK); @(negedge MCLK);
    vectors++; if (und4 !== 1'b0) begin miscompares++; $display("FAIL underrun_r5 got %b want 0", und4); end
    $display("test_reset done");
  endtask

  task automatic test_first_frame();
    bit ok;
    do_reset();
    send(1'b0, 24'h800001, 24'h7FFFFE, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ff_accept got %b want 1", ok); end
    @(negedge MCLK);
    vectors++; if (rdy4 !== 1'b0) begin miscompares++; $display("FAIL ff_ready_drop got %b want 0", rdy4); end
    for (int n = 0; n < 2000 && fq4.size() < 1; n++) @(negedge MCLK);
    vectors++; if (fq4.size() < 1) begin miscompares++; $display("FAIL ff_frames got %0d want 1", fq4.size()); end
    vectors++; if (fq4[0].d !== F0_EXP) begin miscompares++; $display("FAIL ff_data got %h want %h", fq4[0].d, F0_EXP); end
    vectors++; if (fq4[0].lr !== LR_EXP) begin miscompares++; $display("FAIL ff_lrck got %h want %h", fq4[0].lr, LR_EXP); end
    vectors++; if (led4 !== 1'b0) begin miscompares++; $display("FAIL ff_led1 got %b want 0", led4); end
    vectors++; if (urq4.size() != 0) begin miscompares++; $display("FAIL ff_underruns got %0d want 0", urq4.size()); end
    $display("test_first_frame: frame0 %h", fq4[0].d);
  endtask

  task automatic test_underrun();
    logic [63:0] exp_d;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    exp_d = 64'h0;
`else
    exp_d = F0_EXP;
`endif
    for (int n = 0; n < 2000 && fq4.size() < 4; n++) @(negedge MCLK);
    vectors++; if (fq4.size() < 4) begin miscompares++; $display("FAIL ur_frames got %0d want 4", fq4.size()); end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (fq4[i].d !== exp_d) begin miscompares++; $display("FAIL ur_data%0d got %h want %h", i, fq4[i].d, exp_d); end
    end
    vectors++; if (fq4[3].lr !== LR_EXP) begin miscompares++; $display("FAIL ur_lrck got %h want %h", fq4[3].lr, LR_EXP); end
    vectors++; if (urq4.size() != 3) begin miscompares++; $display("FAIL ur_count got %0d want 3", urq4.size()); end
    vectors++; if (urq4[1] - urq4[0] != 256) begin miscompares++; $display("FAIL ur_period1 got %0d want 256", urq4[1] - urq4[0]); end
    vectors++; if (urq4[2] - urq4[1] != 256) begin miscompares++; $display("FAIL ur_period2 got %0d want 256", urq4[2] - urq4[1]); end
    vectors++; if (led4 !== 1'b1) begin miscompares++; $display("FAIL ur_led1 got %b want 1", led4); end
    $display("test_underrun: %0d underrun pulses", urq4.size());
  endtask

  task automatic test_back_to_back();
    bit          ok;
    logic [23:0] el[6];
    logic [23:0] er[6];
    logic [63:0] ef;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      el[k] = 24'h0A0000 + 24'(k);
      er[k] = 24'hF50000 - 24'(k);
      send(1'b0, el[k], er[k], ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL b2b_accept%0d got %b want 1", k, ok); end
    end
    for (int n = 0; n < 3000 && fq4.size() < 6; n++) @(negedge MCLK);
    vectors++; if (fq4.size() < 6) begin miscompares++; $display("FAIL b2b_frames got %0d want 6", fq4.size()); end
    for (int k = 0; k < 6; k++) begin
      ef = build_frame(el[k], er[k]);
      vectors++;
      if (fq4[k].d !== ef) begin miscompares++; $display("FAIL b2b_data%0d got %h want %h", k, fq4[k].d, ef); end
      $display("test_back_to_back: frame %0d data %h", k, fq4[k].d);
    end
    vectors++; if (urq4.size() != 0) begin miscompares++; $display("FAIL b2b_underruns got %0d want 0", urq4.size()); end
    vectors++; if (acq4.size() != 6) begin miscompares++; $display("FAIL b2b_accepts got %0d want 6", acq4.size()); end
    for (int k = 2; k < 6; k++) begin
      vectors++;
      if (acq4[k] - acq4[k-1] != 256) begin miscompares++; $display("FAIL b2b_acc_gap%0d got %0d want 256", k, acq4[k] - acq4[k-1]); end
    end
    vectors++; if (fq4[5].cyc - fq4[4].cyc != 256) begin miscompares++; $display("FAIL b2b_frame_gap got %0d want 256", fq4[5].cyc - fq4[4].cyc); end
  endtask

  task automatic test_load_collision();
    logic [63:0] ef;
    do_reset();
    repeat (3) @(posedge MCLK);
    #1;
    sample_l = 24'h123456;
    sample_r = 24'hABCDEF;
    sample_valid = 1'b1;
    @(posedge MCLK);
    #1 sample_valid = 1'b0;
    @(negedge MCLK);
    vectors++; if (und4 !== 1'b1) begin miscompares++; $display("FAIL col_underrun got %b want 1", und4); end
    vectors++; if (rdy4 !== 1'b0) begin miscompares++; $display("FAIL col_ready got %b want 0", rdy4); end
    vectors++; if (led4 !== 1'b1) begin miscompares++; $display("FAIL col_led1 got %b want 1", led4); end
    @(negedge MCLK);
    vectors++; if (und4 !== 1'b0) begin miscompares++; $display("FAIL col_pulse_width got %b want 0", und4); end
    vectors++; if (acq4.size() != 1) begin miscompares++; $display("FAIL col_accepts got %0d want 1", acq4.size()); end
    for (int n = 0; n < 2000 && fq4.size() < 2; n++) @(negedge MCLK);
    ef = build_frame(24'h123456, 24'hABCDEF);
    vectors++; if (fq4[0].d !== 64'h0) begin miscompares++; $display("FAIL col_frame0 got %h want 0", fq4[0].d); end
    vectors++; if (fq4[1].d !== ef) begin miscompares++; $display("FAIL col_frame1 got %h want %h", fq4[1].d, ef); end
    vectors++; if (urq4.size() != 1) begin miscompares++; $display("FAIL col_underruns got %0d want 1", urq4.size()); end
    vectors++; if (led4 !== 1'b0) begin miscompares++; $display("FAIL col_led1_after got %b want 0", led4); end
    $display("test_load_collision: frame1 %h", fq4[1].d);
  endtask

  task automatic test_reset_midframe();
    bit ok;
    do_reset();
    send(1'b0, 24'h800001, 24'h7FFFFE, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL mid_accept0 got %b want 1", ok); end
    send(1'b0, 24'h111111, 24'h222222, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL mid_accept1 got %b want 1", ok); end
    repeat (160) @(posedge MCLK);
    #1;
    // bc 40 carries right-channel bit 16 of 0x7FFFFE
    vectors++; if (lrck4 !== 1'b1) begin miscompares++; $display("FAIL mid_lrck_bc40 got %b want 1", lrck4); end
    vectors++; if (dout4 !== 1'b1) begin miscompares++; $display("FAIL mid_dout_bc40 got %b want 1", dout4); end
    vectors++; if (rdy4 !== 1'b0) begin miscompares++; $display("FAIL mid_ready_held got %b want 0", rdy4); end
    RST = 1'b1;
    @(posedge MCLK);
    #1 RST = 1'b0;
    @(negedge MCLK);
    vectors++; if (bck4 !== 1'b0) begin miscompares++; $display("FAIL mid_bck got %b want 0", bck4); end
    vectors++; if (lrck4 !== 1'b1) begin miscompares++; $display("FAIL mid_lrck got %b want 1", lrck4); end
    vectors++; if (dout4 !== 1'b0) begin miscompares++; $display("FAIL mid_dout got %b want 0", dout4); end
    vectors++; if (rdy4 !== 1'b0) begin miscompares++; $display("FAIL mid_ready got %b want 0", rdy4); end
    vectors++; if (led4 !== 1'b1) begin miscompares++; $display("FAIL mid_led1 got %b want 1", led4); end
    @(posedge MCLK); @(negedge MCLK);
    vectors++; if (rdy4 !== 1'b1) begin miscompares++; $display("FAIL mid_ready_rise got %b want 1", rdy4); end
    @(posedge MCLK); @(posedge MCLK); @(negedge MCLK);
    vectors++; if (lrck4 !== 1'b1) begin miscompares++; $display("FAIL mid_lrck_r3 got %b want 1", lrck4); end
    @(posedge MCLK); @(negedge MCLK);
    vectors++; if (lrck4 !== 1'b0) begin miscompares++; $display("FAIL mid_lrck_r4 got %b want 0", lrck4); end
    vectors++; if (und4 !== 1'b1) begin miscompares++; $display("FAIL mid_hold_discard got %b want 1", und4); end
    $display("test_reset_midframe done");
  endtask

  task automatic test_bck_div2();
    bit          ok;
    logic [7:0]  s;
    logic [63:0] ef;
    do_reset();
    // The first load coincides with this accept, so the pair goes out in frame 1.
    send(1'b1, 24'h800001, 24'h7FFFFE, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL d2_accept0 got %b want 1", ok); end
    send(1'b1, 24'h5A5A5A, 24'hC3C3C3, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL d2_accept1 got %b want 1", ok); end
    for (int i = 0; i < 8; i++) begin
      @(negedge MCLK);
      s[i] = bck2;
    end
    vectors++; if (s !== 8'hAA && s !== 8'h55) begin miscompares++; $display("FAIL d2_bck_duty got %b want alternating", s); end
    for (int n = 0; n < 2000 && fq2.size() < 3; n++) @(negedge MCLK);
    vectors++; if (fq2.size() < 3) begin miscompares++; $display("FAIL d2_frames got %0d want 3", fq2.size()); end
    vectors++; if (fq2[1].d !== F0_EXP) begin miscompares++; $display("FAIL d2_frame1 got %h want %h", fq2[1].d, F0_EXP); end
    vectors++; if (fq2[1].lr !== LR_EXP) begin miscompares++; $display("FAIL d2_lrck got %h want %h", fq2[1].lr, LR_EXP); end
    ef = build_frame(24'h5A5A5A, 24'hC3C3C3);
    vectors++; if (fq2[2].d !== ef) begin miscompares++; $display("FAIL d2_frame2 got %h want %h", fq2[2].d, ef); end
    vectors++; if (fq2[2].cyc - fq2[1].cyc != 128) begin miscompares++; $display("FAIL d2_frame_period got %0d want 128", fq2[2].cyc - fq2[1].cyc); end
    vectors++; if (urq2.size() != 1) begin miscompares++; $display("FAIL d2_underruns got %0d want 1", urq2.size()); end
    $display("test_bck_div2: frame2 %h", fq2[2].d);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RST = 1'b1;
    sample_l = '0;
    sample_r = '0;
    sample_valid = 1'b0;
    test_reset();
    test_first_frame();
    test_underrun();
    test_back_to_back();
    test_load_collision();
    test_reset_midframe();
    test_bck_div2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
